// File: rtl/booth_operand_sequencer_if.sv
// Handshake bundle between the operand sequencer, its operand source,
// the booth multiplier and the result consumer.
// Ports (via modports):
//   slave  : sequencer side (in_ready, mul_*, out_*, fifo_count driven)
//   master : environment side (in_valid/in_a/in_b, mul_done/product, out_ready)
interface booth_operand_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_a;
    logic [WIDTH-1:0]         in_b;
    logic                     mul_start;
    logic [WIDTH-1:0]         mul_a;
    logic [WIDTH-1:0]         mul_b;
    logic [2*WIDTH-1:0]       mul_product;
    logic                     mul_done;
    logic                     out_valid;
    logic                     out_ready;
    logic [2*WIDTH-1:0]       out_product;
    logic                     out_err;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport slave (
        input  in_valid, in_a, in_b, mul_product, mul_done, out_ready,
        output in_ready, mul_start, mul_a, mul_b,
        output out_valid, out_product, out_err, fifo_count
    );

    modport master (
        output in_valid, in_a, in_b, mul_product, mul_done, out_ready,
        input  in_ready, mul_start, mul_a, mul_b,
        input  out_valid, out_product, out_err, fifo_count
    );
endinterface

// File: rtl/booth_operand_sequencer.sv
// Operand FIFO + start/done sequencer in front of a booth multiplier.
// Ports: clk, rst_n (async, active-low), bus (booth_operand_sequencer_if.slave):
//   operand push (in_*), multiplier start/done (mul_*), result out (out_*),
//   FIFO occupancy (fifo_count).
module booth_operand_sequencer #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    booth_operand_sequencer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL  = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t                r_state;
    logic [2*WIDTH-1:0]    r_mem [DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_count;
    logic [CW-1:0]         r_tcnt;
    logic                  r_start;
    logic [WIDTH-1:0]      r_a;
    logic [WIDTH-1:0]      r_b;
    logic                  r_out_valid;
    logic [2*WIDTH-1:0]    r_out_prod;
    logic                  r_out_err;

    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic [2*WIDTH-1:0]    w_head;

    assign w_full = (r_count == FULL);
    assign w_push = bus.in_valid && !w_full;
    // Pop only from the registered count, so a fresh push is seen next cycle.
    assign w_pop  = (r_state == IDLE) && (r_count != '0);
    assign w_head = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.in_a, bus.in_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tcnt      <= '0;
            r_start     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_out_valid <= 1'b0;
            r_out_prod  <= '0;
            r_out_err   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_a     <= w_head[2*WIDTH-1:WIDTH];
                        r_b     <= w_head[WIDTH-1:0];
                        r_start <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_start <= 1'b0;
                    r_tcnt  <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // r_tcnt==0 marks the first WAIT cycle: a done still
                    // high from the previous op must not be taken.
                    if (r_tcnt != '0 && bus.mul_done) begin
                        r_out_prod  <= bus.mul_product;
                        r_out_err   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else if (r_tcnt == TLAST) begin
                        r_out_prod  <= '0;
                        r_out_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else begin
                        r_tcnt <= r_tcnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = !w_full;
    assign bus.mul_start   = r_start;
    assign bus.mul_a       = r_a;
    assign bus.mul_b       = r_b;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_product = r_out_prod;
    assign bus.out_err     = r_out_err;
    assign bus.fifo_count  = r_count;
endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Directed bench for booth_operand_sequencer with a behavioural multiplier
// stub (pulse / sticky-done / dead modes) and an output scoreboard.
module tb_booth_operand_sequencer;
    localparam int WIDTH   = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int PULSE   = 0;
    localparam int STICKY  = 1;
    localparam int DEAD    = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   n_start = 0;
    int   mode = PULSE;
    int   lat = 2;
    logic prev_start = 1'b0;

    logic [8:0] sb [$];
    logic [7:0] opq [$];

    booth_operand_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    booth_operand_sequencer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Multiplier stub
    logic signed [7:0] m_a, m_b;
    int                m_cnt;
    logic              m_busy, m_dly;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mul_done    <= 1'b0;
            bus.mul_product <= '0;
            m_busy <= 1'b0;
            m_dly  <= 1'b0;
            m_cnt  <= 0;
            m_a    <= '0;
            m_b    <= '0;
        end else if (bus.mul_start) begin
            m_a    <= $signed(bus.mul_a);
            m_b    <= $signed(bus.mul_b);
            m_busy <= 1'b1;
            m_cnt  <= lat;
            if (mode == STICKY) m_dly <= 1'b1;
            else bus.mul_done <= 1'b0;
        end else if (m_dly) begin
            m_dly        <= 1'b0;
            bus.mul_done <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy <= 1'b0;
                if (mode != DEAD) begin
                    bus.mul_done    <= 1'b1;
                    bus.mul_product <= m_a * m_b;
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (mode == PULSE) begin
            bus.mul_done <= 1'b0;
        end
    end

    // Monitor: operand order at each start, results against scoreboard
    always @(negedge clk) begin
        logic [8:0] e;
        logic [7:0] o;
        if (!rst_n) begin
            prev_start = 1'b0;
        end else begin
            if (bus.mul_start) begin
                n_start++;
                chk("start_one_cycle", prev_start, 0);
                chk("start_expected", opq.size() > 0, 1);
                if (opq.size() > 0) begin
                    o = opq.pop_front();
                    chk("mul_a", bus.mul_a, o[7:4]);
                    chk("mul_b", bus.mul_b, o[3:0]);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("result_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("out_product", bus.out_product, e[7:0]);
                    chk("out_err", bus.out_err, e[8]);
                end
            end
            prev_start = bus.mul_start;
        end
    end

    task automatic push(input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp, input logic err);
        int g = 0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("push_ready_bound", bus.in_ready, 1);
        sb.push_back({err, exp});
        opq.push_back({a, b});
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((sb.size() != 0 || opq.size() != 0) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        chk("drain_done", sb.size() + opq.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_in_ready"}, bus.in_ready, 1);
        chk({pfx, "_fifo_count"}, bus.fifo_count, 0);
        chk({pfx, "_mul_start"}, bus.mul_start, 0);
        chk({pfx, "_mul_a"}, bus.mul_a, 0);
        chk({pfx, "_mul_b"}, bus.mul_b, 0);
        chk({pfx, "_out_valid"}, bus.out_valid, 0);
        chk({pfx, "_out_product"}, bus.out_product, 0);
        chk({pfx, "_out_err"}, bus.out_err, 0);
    endtask

    initial begin
        int s0;
        int g;
        int k;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single pair (-3,5) -> -15
        s0 = n_start;
        push(4'hD, 4'h5, 8'hF1, 1'b0);
        drain();
        chk("t1_starts", n_start - s0, 1);

        // 2: back-to-back pairs, results in order
        s0 = n_start;
        push(4'hC, 4'hE, 8'h08, 1'b0);
        push(4'h7, 4'h3, 8'h15, 1'b0);
        push(4'h8, 4'h8, 8'h40, 1'b0);
        drain();
        chk("t2_starts", n_start - s0, 3);

        // 3: consumer stalled, FIFO fills, then drains in order
        bus.out_ready = 1'b0;
        push(4'h1, 4'h2, 8'h02, 1'b0);
        push(4'h2, 4'h3, 8'h06, 1'b0);
        push(4'hF, 4'h3, 8'hFD, 1'b0);
        push(4'hE, 4'hE, 8'h04, 1'b0);
        push(4'h3, 4'hD, 8'hF7, 1'b0);
        chk("t3_full_count", bus.fifo_count, DEPTH);
        chk("t3_in_ready_low", bus.in_ready, 0);
        repeat (10) @(negedge clk);
        chk("t3_stalled_valid", bus.out_valid, 1);
        chk("t3_still_full", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        drain();

        // 4: done left high from previous op must be ignored
        mode = STICKY;
        push(4'h3, 4'h2, 8'h06, 1'b0);
        drain();
        chk("t4_stale_done_high", bus.mul_done, 1);
        push(4'hB, 4'h3, 8'hF1, 1'b0);
        drain();

        // 5: dead multiplier -> timeout abort, then recovery
        mode = DEAD;
        push(4'h2, 4'h2, 8'h00, 1'b1);
        g = 0;
        while (!bus.mul_start && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("t5_start_seen", bus.mul_start, 1);
        k = 0;
        while (!bus.out_valid && k < TIMEOUT + 20) begin
            @(negedge clk);
            k++;
        end
        chk("t5_timeout_latency", k, TIMEOUT + 1);
        drain();
        mode = PULSE;
        push(4'h1, 4'hF, 8'hFF, 1'b0);
        drain();

        // 6: reset in WAIT with two pairs queued
        lat = 20;
        push(4'h1, 4'h1, 8'h01, 1'b0);
        push(4'h2, 4'h2, 8'h04, 1'b0);
        push(4'h3, 4'h3, 8'h09, 1'b0);
        repeat (2) @(negedge clk);
        chk("t6_queued", bus.fifo_count, 2);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_reset");
        sb.delete();
        opq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        s0 = n_start;
        repeat (25) @(negedge clk);
        chk("t6_no_start", n_start - s0, 0);
        chk("t6_no_valid", bus.out_valid, 0);
        chk("t6_empty", bus.fifo_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
